// File: rtl/dcmac_0_ts_ctx_rmw_arb.sv
// Round-robin arbiter and read-modify-write sequencer for the per-ID
// timestamp context memory; one operation per cycle, clears take priority.
module dcmac_0_ts_ctx_rmw_arb #(
    parameter int NUM_REQ  = 2,
    parameter int NUM_ID   = 6,
    parameter int DW       = 16,
    parameter bit SATURATE = 1'b0,
    localparam int ID_W    = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    input  logic [NUM_REQ*DW-1:0]   req_inc,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    clr_valid,
    input  logic [ID_W-1:0]         clr_id,
    output logic                    clr_ready,
    output logic                    rsp_valid,
    output logic [2:0]              rsp_src,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DW-1:0]           rsp_old,
    output logic [DW-1:0]           rsp_new,
    output logic                    rsp_ovf,
    output logic [ID_W-1:0]         mem_rd_id,
    output logic                    mem_ena,
    output logic [DW-1:0]           mem_dat,
    output logic                    mem_rd_during_wr,
    input  logic [DW-1:0]           mem_q,
    input  logic                    mem_init
);

    localparam int PW = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);

    logic [PW-1:0]   rr_q, rr_d;
    logic            gnt_req, gnt_any;
    int              sel, idx;
    logic [2:0]      a_src;
    logic [DW-1:0]   a_inc;

    logic            b_vld_q, b_clr_q;
    logic [2:0]      b_src_q;
    logic [ID_W-1:0] b_id_q;
    logic [DW-1:0]   b_inc_q;
    logic [DW:0]     b_sum;
    logic [DW-1:0]   b_new;
    logic            b_ovf;

    logic            rsp_valid_q, rsp_ovf_q;
    logic [2:0]      rsp_src_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [DW-1:0]   rsp_old_q, rsp_new_q;

    always_comb begin
        req_ready = '0;
        clr_ready = 1'b0;
        gnt_req   = 1'b0;
        sel       = 0;
        idx       = 0;
        mem_rd_id = '0;
        rr_d      = rr_q;
        a_src     = 3'd7;
        a_inc     = '0;
        if (!mem_init) begin
            if (clr_valid) begin
                clr_ready = 1'b1;
                mem_rd_id = clr_id;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (int'(rr_q) + k) % NUM_REQ;
                    if (!gnt_req && req_valid[idx]) begin
                        gnt_req = 1'b1;
                        sel     = idx;
                    end
                end
                if (gnt_req) begin
                    req_ready[sel] = 1'b1;
                    mem_rd_id      = req_id[sel*ID_W +: ID_W];
                    a_src          = 3'(sel);
                    a_inc          = req_inc[sel*DW +: DW];
                    rr_d = (sel == NUM_REQ - 1) ? '0 : PW'(sel + 1);
                end
            end
        end
    end

    assign gnt_any = clr_ready | gnt_req;

    // Forwarding lets a same-ID op granted now read the value being written.
    assign mem_rd_during_wr = b_vld_q && gnt_any && (mem_rd_id == b_id_q);

    always_comb begin
        b_sum = {1'b0, mem_q} + {1'b0, b_inc_q};
        b_new = b_sum[DW-1:0];
        b_ovf = b_sum[DW];
        if (SATURATE && b_sum[DW]) begin
            b_new = '1;
        end
        if (b_clr_q) begin
            b_new = '0;
            b_ovf = 1'b0;
        end
    end

    assign mem_ena = b_vld_q;
    assign mem_dat = b_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            b_vld_q     <= 1'b0;
            b_clr_q     <= 1'b0;
            b_src_q     <= '0;
            b_id_q      <= '0;
            b_inc_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= '0;
            rsp_id_q    <= '0;
            rsp_old_q   <= '0;
            rsp_new_q   <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            b_vld_q     <= gnt_any;
            b_clr_q     <= clr_ready;
            rsp_valid_q <= b_vld_q;
            if (gnt_any) begin
                b_src_q <= a_src;
                b_id_q  <= mem_rd_id;
                b_inc_q <= a_inc;
            end
            if (b_vld_q) begin
                rsp_src_q <= b_src_q;
                rsp_id_q  <= b_id_q;
                rsp_old_q <= mem_q;
                rsp_new_q <= b_new;
                rsp_ovf_q <= b_ovf;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_old   = rsp_old_q;
    assign rsp_new   = rsp_new_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_dcmac_0_ts_ctx_rmw_arb.sv
// Bench for the context RMW arbiter: directed scenarios then random traffic,
// with a modulo instance and a saturating instance checked against a model.
module tb_dcmac_0_ts_ctx_rmw_arb;

    typedef struct {
        bit v;
        int src;
        int id;
        int old;
        int nw;
        bit ovf;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [5:0]  req_id = '0;
    logic [31:0] req_inc = '0;
    logic        clr_valid = 1'b0;
    logic [2:0]  clr_id = '0;
    logic        mem_init = 1'b1;

    logic [1:0]  rdy[2];
    logic        crdy[2], rv[2], rovf[2], mena[2], mrdw[2];
    logic [2:0]  rsrc[2], rid[2], mrd[2], wid[2];
    logic [15:0] rold[2], rnew[2], mdat[2], mq[2];
    logic [15:0] mem0[6], mem1[6];

    logic        pl_en = 1'b0;
    logic [2:0]  pl_id = '0;
    logic [15:0] pl_val = '0;

    int   npass = 0, ntot = 0, nfail = 0;
    int   ctx[2][6];
    op_t  pb[2], pr[2];
    int   rr = 0;
    int   last_g = -1;

    always #5 clk = ~clk;

    dcmac_0_ts_ctx_rmw_arb #(.NUM_REQ(2), .NUM_ID(6), .DW(16), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
        .req_inc(req_inc), .req_ready(rdy[0]), .clr_valid(clr_valid),
        .clr_id(clr_id), .clr_ready(crdy[0]), .rsp_valid(rv[0]),
        .rsp_src(rsrc[0]), .rsp_id(rid[0]), .rsp_old(rold[0]),
        .rsp_new(rnew[0]), .rsp_ovf(rovf[0]), .mem_rd_id(mrd[0]),
        .mem_ena(mena[0]), .mem_dat(mdat[0]), .mem_rd_during_wr(mrdw[0]),
        .mem_q(mq[0]), .mem_init(mem_init)
    );

    dcmac_0_ts_ctx_rmw_arb #(.NUM_REQ(2), .NUM_ID(6), .DW(16), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
        .req_inc(req_inc), .req_ready(rdy[1]), .clr_valid(clr_valid),
        .clr_id(clr_id), .clr_ready(crdy[1]), .rsp_valid(rv[1]),
        .rsp_src(rsrc[1]), .rsp_id(rid[1]), .rsp_old(rold[1]),
        .rsp_new(rnew[1]), .rsp_ovf(rovf[1]), .mem_rd_id(mrd[1]),
        .mem_ena(mena[1]), .mem_dat(mdat[1]), .mem_rd_during_wr(mrdw[1]),
        .mem_q(mq[1]), .mem_init(mem_init)
    );

    // Context memories: write lands on the ID read one cycle earlier.
    always @(posedge clk) begin
        if (pl_en) mem0[pl_id] <= pl_val;
        else if (mena[0]) mem0[wid[0]] <= mdat[0];
        mq[0]  <= mrdw[0] ? mdat[0] : mem0[mrd[0]];
        wid[0] <= mrd[0];
    end

    always @(posedge clk) begin
        if (pl_en) mem1[pl_id] <= pl_val;
        else if (mena[1]) mem1[wid[1]] <= mdat[1];
        mq[1]  <= mrdw[1] ? mdat[1] : mem1[mrd[1]];
        wid[1] <= mrd[1];
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(int id, int val);
        pl_en  = 1'b1;
        pl_id  = 3'(id);
        pl_val = 16'(val);
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        ctx[0][id] = val;
        ctx[1][id] = val;
    endtask

    task automatic step();
        int g;
        int rd_e;
        int sum;
        @(negedge clk);
        g = -1;
        if (!mem_init) begin
            if (clr_valid) g = -2;
            else begin
                for (int k = 0; k < 2; k++) begin
                    int ix;
                    ix = (rr + k) % 2;
                    if (g == -1 && req_valid[ix]) g = ix;
                end
            end
        end
        rd_e = (g == -2) ? int'(clr_id) : (g >= 0) ? int'(req_id[g*3 +: 3]) : 0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 32'(rdy[d]), (g >= 0) ? (1 << g) : 0);
            chk($sformatf("clr_ready%0d", d), 32'(crdy[d]), 32'(g == -2));
            chk($sformatf("mem_rd_id%0d", d), 32'(mrd[d]), rd_e);
            chk($sformatf("mem_ena%0d", d), 32'(mena[d]), 32'(pb[d].v));
            if (pb[d].v) chk($sformatf("mem_dat%0d", d), 32'(mdat[d]), pb[d].nw);
            chk($sformatf("rd_during_wr%0d", d), 32'(mrdw[d]),
                32'(pb[d].v && g != -1 && rd_e == pb[d].id));
            chk($sformatf("rsp_valid%0d", d), 32'(rv[d]), 32'(pr[d].v));
            if (pr[d].v) begin
                chk($sformatf("rsp_src%0d", d), 32'(rsrc[d]), pr[d].src);
                chk($sformatf("rsp_id%0d", d), 32'(rid[d]), pr[d].id);
                chk($sformatf("rsp_old%0d", d), 32'(rold[d]), pr[d].old);
                chk($sformatf("rsp_new%0d", d), 32'(rnew[d]), pr[d].nw);
                chk($sformatf("rsp_ovf%0d", d), 32'(rovf[d]), 32'(pr[d].ovf));
            end
        end
        for (int d = 0; d < 2; d++) begin
            pr[d] = pb[d];
            pb[d] = '{v: 0, src: 0, id: 0, old: 0, nw: 0, ovf: 0};
            if (g != -1) begin
                pb[d].v   = 1;
                pb[d].id  = rd_e;
                pb[d].old = ctx[d][rd_e];
                if (g == -2) begin
                    pb[d].src = 7;
                end else begin
                    pb[d].src = g;
                    sum = pb[d].old + int'(req_inc[g*16 +: 16]);
                    pb[d].ovf = (sum > 65535);
                    if (d == 1) pb[d].nw = (sum > 65535) ? 65535 : sum;
                    else pb[d].nw = sum % 65536;
                end
                ctx[d][rd_e] = pb[d].nw;
            end
        end
        if (g >= 0) rr = (g + 1) % 2;
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_mem_ena%0d", d), 32'(mena[d]), 0);
            chk($sformatf("rst_rsp_valid%0d", d), 32'(rv[d]), 0);
            if (pb[d].v) ctx[d][pb[d].id] = pb[d].old;
            pb[d] = '{v: 0, src: 0, id: 0, old: 0, nw: 0, ovf: 0};
            pr[d] = '{v: 0, src: 0, id: 0, old: 0, nw: 0, ovf: 0};
        end
        rr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(int n);
        req_valid = '0;
        clr_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pb[d] = '{v: 0, src: 0, id: 0, old: 0, nw: 0, ovf: 0};
            pr[d] = '{v: 0, src: 0, id: 0, old: 0, nw: 0, ovf: 0};
        end
        for (int i = 0; i < 6; i++) preload(i, 0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_rsp_valid", 32'(rv[d]), 0);
            chk("reset_rsp_src", 32'(rsrc[d]), 0);
            chk("reset_rsp_id", 32'(rid[d]), 0);
            chk("reset_rsp_old", 32'(rold[d]), 0);
            chk("reset_rsp_new", 32'(rnew[d]), 0);
            chk("reset_rsp_ovf", 32'(rovf[d]), 0);
            chk("reset_mem_ena", 32'(mena[d]), 0);
            chk("reset_rd_during_wr", 32'(mrdw[d]), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Init sweep blocks grants, then alternating same-ID chain.
        req_valid = 2'b11;
        req_id    = {3'd2, 3'd2};
        req_inc   = {16'd1, 16'd1};
        for (int i = 0; i < 6; i++) step();
        mem_init = 1'b0;
        for (int i = 0; i < 8; i++) step();
        drain(3);

        // Wrap versus clamp on id 3.
        preload(3, 16'hFFFE);
        req_valid = 2'b01;
        req_id    = {3'd0, 3'd3};
        req_inc   = {16'd0, 16'd3};
        step();
        drain(3);

        // Clear wins over a same-cycle request to the same ID.
        preload(1, 16'h1234);
        clr_valid = 1'b1;
        clr_id    = 3'd1;
        req_valid = 2'b10;
        req_id    = {3'd1, 3'd0};
        req_inc   = {16'd5, 16'd0};
        step();
        clr_valid = 1'b0;
        step();
        drain(3);

        // Reset one cycle after a grant drops the in-flight write.
        req_valid = 2'b11;
        req_id    = {3'd4, 3'd4};
        req_inc   = {16'd2, 16'd2};
        step();
        reset_pulse();
        step();
        step();
        drain(3);

        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    req_valid[i] = ($urandom % 4) != 0;
                    req_id[i*3 +: 3] = 3'($urandom % 6);
                    req_inc[i*16 +: 16] = (($urandom % 8) == 0) ?
                        16'($urandom) : 16'($urandom % 4);
                end
            end
            if (!clr_valid || last_g == -2) begin
                clr_valid = ($urandom % 10) == 0;
                clr_id    = 3'($urandom % 6);
            end
            mem_init = ($urandom % 16) == 0;
            step();
        end
        mem_init = 1'b0;
        drain(4);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
